// File: rtl/deser_pkg.sv
// Shared types and defaults for the serial-to-parallel frame receiver.
// DESER_PARITY_EN adds the PAR state for the trailing even-parity bit.
package deser_pkg;

  localparam int DESER_WIDTH_DEF = 32;

`ifdef DESER_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2,
    ST_HOLD  = 2'd3
  } deser_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd3
  } deser_state_t;
`endif

endpackage

// File: rtl/sipo_shift.sv
// LSB-first shift register with saturating bit counter, falling-edge clocked.
// clr resets only the counter; the register keeps its contents until shifted.
module sipo_shift
  import deser_pkg::*;
#(
  parameter int WIDTH = DESER_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         r_n,
  input  logic                         clr,
  input  logic                         en,
  input  logic                         sin,
  output logic [WIDTH-1:0]             q,
  output logic [$clog2(WIDTH+1)-1:0]   cnt
);

  localparam int CW = $clog2(WIDTH + 1);

  always_ff @(negedge clk or negedge r_n) begin
    if (!r_n) begin
      q   <= '0;
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      q <= {sin, q[WIDTH-1:1]};
      if (cnt != CW'(WIDTH))
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/deserializer_32b.sv
// Framed serial-in/parallel-out receiver with hold/handshake and overrun flag.
// Define DESER_PARITY_EN to capture a trailing even-parity bit and expose par_err.
module deserializer_32b
  import deser_pkg::*;
#(
  parameter int WIDTH = DESER_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             r_n,
  input  logic             start,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data,
  output logic             data_valid,
  output logic             busy,
  output logic             overrun
`ifdef DESER_PARITY_EN
  ,
  output logic             par_err
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  deser_state_t     state, state_nx;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] held;
  logic [CW-1:0]    cnt;
  logic             clr, en, last;

  assign last = (cnt == CW'(WIDTH - 1));

  sipo_shift #(.WIDTH(WIDTH)) u_sipo (
    .clk (clk),
    .r_n (r_n),
    .clr (clr),
    .en  (en),
    .sin (sin),
    .q   (shreg),
    .cnt (cnt)
  );

  always_comb begin
    state_nx = state;
    clr      = 1'b0;
    en       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx = ST_SHIFT;
          clr      = 1'b1;
        end
      end
      ST_SHIFT: begin
        // a new start aborts the frame; the start edge never captures sin
        if (start) begin
          clr = 1'b1;
        end else if (sin_valid) begin
          en = 1'b1;
          if (last)
`ifdef DESER_PARITY_EN
            state_nx = ST_PAR;
`else
            state_nx = ST_HOLD;
`endif
        end
      end
`ifdef DESER_PARITY_EN
      ST_PAR: begin
        if (start) begin
          state_nx = ST_SHIFT;
          clr      = 1'b1;
        end else if (sin_valid) begin
          state_nx = ST_HOLD;
        end
      end
`endif
      ST_HOLD: begin
        if (out_ready) begin
          state_nx = start ? ST_SHIFT : ST_IDLE;
          clr      = start;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(negedge clk or negedge r_n) begin
    if (!r_n) begin
      state   <= ST_IDLE;
      held    <= '0;
      overrun <= 1'b0;
`ifdef DESER_PARITY_EN
      par_err <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      // snapshot on acknowledge so data stays put once the register refills
      if (state == ST_HOLD && out_ready)
        held <= shreg;
      if (state == ST_HOLD && start && !out_ready)
        overrun <= 1'b1;
`ifdef DESER_PARITY_EN
      if (state == ST_PAR && !start && sin_valid)
        par_err <= (^shreg) ^ sin;
`endif
    end
  end

  assign data       = (state == ST_HOLD) ? shreg : held;
  assign data_valid = (state == ST_HOLD);
`ifdef DESER_PARITY_EN
  assign busy       = (state == ST_SHIFT) || (state == ST_PAR);
`else
  assign busy       = (state == ST_SHIFT);
`endif

endmodule

// File: tb/tb_deserializer_32b.sv
// Directed bench for deserializer_32b; inputs change and outputs are sampled 1ns after each falling edge.
// Build with +define+DESER_PARITY_EN to include the parity-bit frames and par_err checks.
module tb_deserializer_32b;

  logic        clk = 1'b0;
  logic        r_n = 1'b0;
  logic        start = 1'b0;
  logic        sin = 1'b0;
  logic        sin_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] data;
  logic        data_valid;
  logic        busy;
  logic        overrun;
`ifdef DESER_PARITY_EN
  logic        par_err;
`endif

  int checks = 0;
  int errors = 0;

  deserializer_32b #(.WIDTH(32)) dut (
    .clk        (clk),
    .r_n        (r_n),
    .start      (start),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .out_ready  (out_ready),
    .data       (data),
    .data_valid (data_valid),
    .busy       (busy),
    .overrun    (overrun)
`ifdef DESER_PARITY_EN
    ,
    .par_err    (par_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    sin       = b;
    sin_valid = 1'b1;
    tick();
    sin_valid = 1'b0;
  endtask

  // 32 data bits LSB first (optionally with 1-3 idle cycles between bits), then the parity bit if enabled
  task automatic send_frame(input logic [31:0] w, input bit gaps, input logic pbit);
    for (int i = 0; i < 32; i++) begin
      send_bit(w[i]);
      if (gaps && i < 31) begin
        for (int g = 0; g < (i % 3) + 1; g++) begin
          sin = ~sin;
          tick();
          if (busy !== 1'b1) begin
            $display("FAIL gap_busy bit%0d got %b exp 1", i, busy);
            errors++;
          end
          checks++;
        end
      end
    end
`ifdef DESER_PARITY_EN
    send_bit(pbit);
`else
    if (pbit === 1'bx) $display("unexpected x parity argument");
`endif
  endtask

  task automatic test_reset();
    r_n = 1'b0;
    tick();
    if (data !== 32'h0) begin $display("FAIL rst_data got %h exp 0", data); errors++; end
    checks++;
    if (data_valid !== 1'b0) begin $display("FAIL rst_dv got %b exp 0", data_valid); errors++; end
    checks++;
    if (busy !== 1'b0) begin $display("FAIL rst_busy got %b exp 0", busy); errors++; end
    checks++;
    if (overrun !== 1'b0) begin $display("FAIL rst_ovr got %b exp 0", overrun); errors++; end
    checks++;
    r_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [31:0] w;
    w = 32'hDEADBEEF;
    do_start();
    for (int i = 0; i < 31; i++) send_bit(w[i]);
    if (data_valid !== 1'b0) begin $display("FAIL basic_dv_early got %b exp 0", data_valid); errors++; end
    checks++;
    if (busy !== 1'b1) begin $display("FAIL basic_busy_mid got %b exp 1", busy); errors++; end
    checks++;
    send_bit(w[31]);
`ifdef DESER_PARITY_EN
    if (data_valid !== 1'b0) begin $display("FAIL basic_dv_before_par got %b exp 0", data_valid); errors++; end
    checks++;
    send_bit(^w);
`endif
    if (data_valid !== 1'b1) begin $display("FAIL basic_dv got %b exp 1", data_valid); errors++; end
    checks++;
    if (data !== 32'hDEADBEEF) begin $display("FAIL basic_data got %h exp deadbeef", data); errors++; end
    checks++;
    if (busy !== 1'b0) begin $display("FAIL basic_busy got %b exp 0", busy); errors++; end
    checks++;
    // sin_valid while holding is ignored and the word stays put
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    if (data !== 32'hDEADBEEF || data_valid !== 1'b1) begin
      $display("FAIL basic_hold got %h/%b exp deadbeef/1", data, data_valid); errors++;
    end
    checks++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    if (data_valid !== 1'b0) begin $display("FAIL basic_ack_dv got %b exp 0", data_valid); errors++; end
    checks++;
    if (data !== 32'hDEADBEEF) begin $display("FAIL basic_ack_data got %h exp deadbeef", data); errors++; end
    checks++;
  endtask

  task automatic test_gaps();
    do_start();
    send_frame(32'hDEADBEEF, 1'b1, 1'b0);
    if (data_valid !== 1'b1) begin $display("FAIL gaps_dv got %b exp 1", data_valid); errors++; end
    checks++;
    if (data !== 32'hDEADBEEF) begin $display("FAIL gaps_data got %h exp deadbeef", data); errors++; end
    checks++;
    if (busy !== 1'b0) begin $display("FAIL gaps_busy got %b exp 0", busy); errors++; end
    checks++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_abort();
    logic [31:0] junk;
    junk = 32'h000003FF;
    do_start();
    for (int i = 0; i < 10; i++) send_bit(junk[i]);
    do_start();
    send_frame(32'h12345678, 1'b0, 1'b1);
    if (data !== 32'h12345678) begin $display("FAIL abort_data got %h exp 12345678", data); errors++; end
    checks++;
    if (data_valid !== 1'b1) begin $display("FAIL abort_dv got %b exp 1", data_valid); errors++; end
    checks++;
    if (overrun !== 1'b0) begin $display("FAIL abort_ovr got %b exp 0", overrun); errors++; end
    checks++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_start();
    send_frame(32'h0F0F0F0F, 1'b0, 1'b0);
    start     = 1'b1;
    out_ready = 1'b1;
    tick();
    start     = 1'b0;
    out_ready = 1'b0;
    if (data_valid !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL b2b_state got dv=%b busy=%b exp dv=0 busy=1", data_valid, busy); errors++;
    end
    checks++;
    if (overrun !== 1'b0) begin $display("FAIL b2b_ovr got %b exp 0", overrun); errors++; end
    checks++;
    if (data !== 32'h0F0F0F0F) begin $display("FAIL b2b_held got %h exp 0f0f0f0f", data); errors++; end
    checks++;
    send_frame(32'hCAFEF00D, 1'b0, 1'b1);
    if (data !== 32'hCAFEF00D || data_valid !== 1'b1) begin
      $display("FAIL b2b_data got %h/%b exp cafef00d/1", data, data_valid); errors++;
    end
    checks++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_overrun();
    do_start();
    send_frame(32'hA5A50F0F, 1'b0, 1'b0);
    do_start();
    if (overrun !== 1'b1) begin $display("FAIL ovr_flag got %b exp 1", overrun); errors++; end
    checks++;
    if (data !== 32'hA5A50F0F || data_valid !== 1'b1) begin
      $display("FAIL ovr_held got %h/%b exp a5a50f0f/1", data, data_valid); errors++;
    end
    checks++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    if (data_valid !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL ovr_ack got dv=%b busy=%b exp 0/0", data_valid, busy); errors++;
    end
    checks++;
    if (overrun !== 1'b1) begin $display("FAIL ovr_sticky got %b exp 1", overrun); errors++; end
    checks++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] w;
    w = 32'hFFFFFFFF;
    do_start();
    for (int i = 0; i < 20; i++) send_bit(w[i]);
    r_n = 1'b0;
    #1;
    if (data !== 32'h0 || data_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      $display("FAIL midrst_outs got data=%h dv=%b busy=%b ovr=%b exp all 0", data, data_valid, busy, overrun);
      errors++;
    end
    checks++;
`ifdef DESER_PARITY_EN
    if (par_err !== 1'b0) begin $display("FAIL midrst_par got %b exp 0", par_err); errors++; end
    checks++;
`endif
    tick();
    r_n = 1'b1;
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    if (busy !== 1'b0 || data_valid !== 1'b0) begin
      $display("FAIL idle_ignore got busy=%b dv=%b exp 0/0", busy, data_valid); errors++;
    end
    checks++;
    do_start();
    send_frame(32'h00000001, 1'b0, 1'b1);
    if (data !== 32'h00000001 || data_valid !== 1'b1) begin
      $display("FAIL midrst_frame got %h/%b exp 00000001/1", data, data_valid); errors++;
    end
    checks++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

`ifdef DESER_PARITY_EN
  task automatic test_parity();
    do_start();
    send_frame(32'h00000003, 1'b0, 1'b1);
    if (par_err !== 1'b1 || data !== 32'h00000003) begin
      $display("FAIL par_bad got par_err=%b data=%h exp 1/00000003", par_err, data); errors++;
    end
    checks++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    do_start();
    send_frame(32'h00000003, 1'b0, 1'b0);
    if (par_err !== 1'b0 || data_valid !== 1'b1) begin
      $display("FAIL par_good got par_err=%b dv=%b exp 0/1", par_err, data_valid); errors++;
    end
    checks++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_abort();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
`ifdef DESER_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
